// File: rtl/sccb_target_pkg.sv
// rtl/sccb_target_pkg.sv - shared SCCB responder constants, state codes and ID match helper
package sccb_target_pkg;

   localparam logic [7:0] SCCB_ID_OV7670 = 8'h42;
   localparam logic [3:0] PHASE_BITS     = 4'd9;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_ID       = 4'd1;
   localparam logic [3:0] ST_ID_ACK   = 4'd2;
   localparam logic [3:0] ST_SUB      = 4'd3;
   localparam logic [3:0] ST_SUB_ACK  = 4'd4;
   localparam logic [3:0] ST_DATA     = 4'd5;
   localparam logic [3:0] ST_DATA_ACK = 4'd6;
   localparam logic [3:0] ST_RD_DATA  = 4'd7;
   localparam logic [3:0] ST_RD_NA    = 4'd8;
   localparam logic [3:0] ST_IGNORE   = 4'd9;

   // The R/W bit (bit 0) never takes part in address matching.
   function automatic logic id_match(input logic [7:0] rx_id, input logic [7:0] dev_id);
      return (rx_id | 8'h01) == (dev_id | 8'h01);
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - 2-FF synchronizer with rise/fall detect for one SCCB line
module sccb_line_sync (
   input  logic CLK,
   input  logic RST,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] r_pipe;

   // Preset high so an idle bus produces no edge when reset is released.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_pipe <= 3'b111;
      end else begin
         r_pipe <= {r_pipe[1:0], i_line};
      end
   end

   assign o_level = r_pipe[1];
   assign o_rise  = r_pipe[1] & ~r_pipe[2];
   assign o_fall  = ~r_pipe[1] & r_pipe[2];

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB responder: decodes 3-phase writes and 2-phase reads
module sccb_target
   import sccb_target_pkg::*;
#(
   parameter logic [7:0] DeviceID = SCCB_ID_OV7670,
   parameter bit         DriveAck = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_sio_c,
   input  logic       i_sio_d,
   output logic       o_sio_d_oe,
   output logic [7:0] o_sub_addr,
   output logic [7:0] o_wr_data,
   output logic       o_wr_valid,
   input  logic [7:0] i_rd_data,
   output logic       o_busy
);

   logic       w_c_level;
   logic       w_c_rise;
   logic       w_c_fall;
   logic       w_d_level;
   logic       w_d_rise;
   logic       w_d_fall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_shift_in;

   logic [3:0] r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_rw;
   logic       r_oe;
   logic       r_busy;
   logic [7:0] r_sub_addr;
   logic [7:0] r_wr_data;
   logic       r_wr_pend;
   logic       r_wr_valid;

   sccb_line_sync u_sync_c (
      .CLK     (CLK),
      .RST     (RST),
      .i_line  (i_sio_c),
      .o_level (w_c_level),
      .o_rise  (w_c_rise),
      .o_fall  (w_c_fall)
   );

   sccb_line_sync u_sync_d (
      .CLK     (CLK),
      .RST     (RST),
      .i_line  (i_sio_d),
      .o_level (w_d_level),
      .o_rise  (w_d_rise),
      .o_fall  (w_d_fall)
   );

   assign w_start    = w_d_fall & w_c_level;
   assign w_stop     = w_d_rise & w_c_level;
   assign w_shift_in = {r_shift[6:0], w_d_level};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 4'd0;
         r_shift    <= 8'd0;
         r_rw       <= 1'b0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_sub_addr <= 8'd0;
         r_wr_data  <= 8'd0;
         r_wr_pend  <= 1'b0;
         r_wr_valid <= 1'b0;
      end else begin
         // The strobe pipeline sits outside the FSM priority chain so a START cannot swallow it.
         r_wr_pend  <= 1'b0;
         r_wr_valid <= r_wr_pend;
         if (w_stop) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
         end else if (w_start) begin
            r_state   <= ST_ID;
            r_bit_cnt <= 4'd0;
            r_oe      <= 1'b0;
         end else if (w_c_rise) begin
            case (r_state)
               ST_ID: begin
                  r_shift   <= w_shift_in;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     if (id_match(w_shift_in, DeviceID)) begin
                        r_state <= ST_ID_ACK;
                        r_busy  <= 1'b1;
                        r_rw    <= w_d_level;
                     end else begin
                        r_state <= ST_IGNORE;
                     end
                  end
               end
               ST_SUB: begin
                  r_shift   <= w_shift_in;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     r_sub_addr <= w_shift_in;
                     r_state    <= ST_SUB_ACK;
                  end
               end
               ST_DATA: begin
                  r_shift   <= w_shift_in;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     r_wr_data <= w_shift_in;
                     r_wr_pend <= 1'b1;
                     r_state   <= ST_DATA_ACK;
                  end
               end
               ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
               ST_RD_DATA: begin
                  // Rotate so the next bit to drive is always at bit 7.
                  r_shift   <= {r_shift[6:0], r_shift[7]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     r_state <= ST_RD_NA;
                  end
               end
               ST_RD_NA: begin
                  r_state <= ST_IGNORE;
               end
               default: begin
               end
            endcase
         end else if (w_c_fall) begin
            case (r_state)
               ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                  if (r_bit_cnt == PHASE_BITS - 4'd1) begin
                     r_oe <= DriveAck;
                  end else if (r_bit_cnt == PHASE_BITS) begin
                     r_oe      <= 1'b0;
                     r_bit_cnt <= 4'd0;
                     if (r_state == ST_SUB_ACK) begin
                        r_state <= ST_DATA;
                     end else if (r_state == ST_DATA_ACK) begin
                        r_state <= ST_IGNORE;
                     end else if (r_rw) begin
                        r_state <= ST_RD_DATA;
                        r_shift <= i_rd_data;
                        r_oe    <= ~i_rd_data[7];
                     end else begin
                        r_state <= ST_SUB;
                     end
                  end
               end
               ST_RD_DATA: begin
                  r_oe <= ~r_shift[7];
               end
               ST_RD_NA, ST_IGNORE: begin
                  r_oe <= 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_sio_d_oe = r_oe;
   assign o_sub_addr = r_sub_addr;
   assign o_wr_data  = r_wr_data;
   assign o_wr_valid = r_wr_valid;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed bench with a bus-functional SCCB initiator
`timescale 1ns/1ps
module tb_sccb_target;

   localparam int Q = 625;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sio_d;
   logic       o_sio_d_oe;
   logic [7:0] o_sub_addr;
   logic [7:0] o_wr_data;
   logic       o_wr_valid;
   logic [7:0] i_rd_data;
   logic       o_busy;

   int         n_tests = 0;
   int         n_fail = 0;
   int         wr_cnt = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] last_data = 8'h00;
   logic       busy_seen = 1'b0;
   logic       ack;
   logic [7:0] rd;

   assign sio_d = m_sda & ~o_sio_d_oe;

   function automatic logic [7:0] rd_mem(input logic [7:0] a);
      case (a)
         8'h00:   return 8'hC3;
         8'h3A:   return 8'h04;
         8'h77:   return 8'h9E;
         default: return a ^ 8'hFF;
      endcase
   endfunction

   assign i_rd_data = rd_mem(o_sub_addr);

   sccb_target #(.DeviceID(8'h42), .DriveAck(1'b1)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .i_sio_c    (m_scl),
      .i_sio_d    (sio_d),
      .o_sio_d_oe (o_sio_d_oe),
      .o_sub_addr (o_sub_addr),
      .o_wr_data  (o_wr_data),
      .o_wr_valid (o_wr_valid),
      .i_rd_data  (i_rd_data),
      .o_busy     (o_busy)
   );

   always #10 CLK = ~CLK;

   always @(negedge CLK) begin
      if (o_wr_valid) begin
         wr_cnt    <= wr_cnt + 1;
         last_addr <= o_sub_addr;
         last_data <= o_wr_data;
      end
      if (o_busy) busy_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_start();
      m_sda = 1'b1; #(Q);
      m_scl = 1'b1; #(Q);
      m_sda = 1'b0; #(Q);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; #(Q);
      m_scl = 1'b1; #(Q);
      m_sda = 1'b1; #(2*Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; #(Q);
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_sda = 1'b1; #(Q);
      m_scl = 1'b1; #(Q);
      @(negedge CLK);
      b = sio_d;
      #(Q);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(a);
   endtask

   task automatic recv_byte(output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(1'b1);
   endtask

   initial begin
      #(100);
      @(negedge CLK);
      check("rst oe", o_sio_d_oe, 0);
      check("rst addr", o_sub_addr, 0);
      check("rst data", o_wr_data, 0);
      check("rst valid", o_wr_valid, 0);
      check("rst busy", o_busy, 0);
      RST = 1'b1;
      #(4*Q);

      bus_start();
      send_byte(8'h43, ack); check("rd0 id ack", ack, 0);
      recv_byte(rd);         check("rd0 data addr0", rd, 8'hC3);
      bus_stop();

      bus_start();
      send_byte(8'h42, ack); check("t1 id ack", ack, 0);
      send_byte(8'h12, ack); check("t1 sub ack", ack, 0);
      send_byte(8'h80, ack); check("t1 data ack", ack, 0);
      @(negedge CLK);
      check("t1 busy", o_busy, 1);
      bus_stop();
      @(negedge CLK);
      check("t1 busy after stop", o_busy, 0);
      check("t1 strobes", wr_cnt, 1);
      check("t1 addr", last_addr, 8'h12);
      check("t1 data", last_data, 8'h80);

      busy_seen = 1'b0;
      bus_start();
      send_byte(8'h60, ack); check("t2 id nack", ack, 1);
      send_byte(8'h34, ack); check("t2 sub nack", ack, 1);
      send_byte(8'h56, ack); check("t2 data nack", ack, 1);
      bus_stop();
      check("t2 strobes", wr_cnt, 1);
      check("t2 busy", busy_seen, 0);
      bus_start();
      send_byte(8'h42, ack); check("t2b id ack", ack, 0);
      send_byte(8'h20, ack); check("t2b sub ack", ack, 0);
      send_byte(8'hA5, ack); check("t2b data ack", ack, 0);
      bus_stop();
      check("t2b strobes", wr_cnt, 2);
      check("t2b addr", last_addr, 8'h20);
      check("t2b data", last_data, 8'hA5);

      bus_start();
      send_byte(8'h42, ack); check("t3 id ack", ack, 0);
      send_byte(8'h3A, ack); check("t3 sub ack", ack, 0);
      bus_stop();
      @(negedge CLK);
      check("t3 sub kept", o_sub_addr, 8'h3A);
      check("t3 strobes", wr_cnt, 2);
      bus_start();
      send_byte(8'h43, ack); check("t3 rd id ack", ack, 0);
      recv_byte(rd);         check("t3 rd data", rd, 8'h04);
      @(negedge CLK);
      check("t3 oe after na", o_sio_d_oe, 0);
      bus_stop();

      bus_start();
      send_byte(8'h42, ack); check("t4 id ack", ack, 0);
      send_byte(8'h11, ack); check("t4 sub ack", ack, 0);
      send_byte(8'h01, ack); check("t4 data ack", ack, 0);
      send_byte(8'h55, ack); check("t4 extra nack", ack, 1);
      bus_stop();
      check("t4 strobes", wr_cnt, 3);
      check("t4 addr", last_addr, 8'h11);
      check("t4 data", last_data, 8'h01);

      bus_start();
      send_byte(8'h42, ack); check("t5 id ack", ack, 0);
      send_byte(8'h77, ack); check("t5 sub ack", ack, 0);
      bus_start();
      send_byte(8'h43, ack); check("t5 rd id ack", ack, 0);
      recv_byte(rd);         check("t5 rd data", rd, 8'h9E);
      bus_stop();
      check("t5 strobes", wr_cnt, 3);

      bus_start();
      send_byte(8'h42, ack); check("t6 id ack", ack, 0);
      send_byte(8'h5C, ack); check("t6 sub ack", ack, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      m_sda = 1'b0; #(Q);
      m_scl = 1'b1; #(Q);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("t6 rst oe", o_sio_d_oe, 0);
      check("t6 rst busy", o_busy, 0);
      check("t6 rst addr", o_sub_addr, 0);
      check("t6 rst data", o_wr_data, 0);
      check("t6 rst valid", o_wr_valid, 0);
      m_sda = 1'b1;
      #(2*Q);
      RST = 1'b1;
      #(4*Q);
      bus_start();
      send_byte(8'h42, ack); check("t6b id ack", ack, 0);
      send_byte(8'h6B, ack); check("t6b sub ack", ack, 0);
      send_byte(8'h3C, ack); check("t6b data ack", ack, 0);
      bus_stop();
      check("t6b strobes", wr_cnt, 4);
      check("t6b addr", last_addr, 8'h6B);
      check("t6b data", last_data, 8'h3C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
